// File: rtl/bist_pkg.sv
// Shared types and per-element constant tables for the March C- BIST sequencer.
package bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_e;

  localparam int NUM_ELEMS = 6;

  // Indexed by march_elem_e; bits above NUM_ELEMS-1 are padding for the 3-bit index.
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  localparam logic [7:0] ELEM_RD_POL  = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_POL  = 8'b0000_1010;

endpackage

// File: rtl/bist_addr_cnt.sv
// ADDR_W-bit up/down address counter with load-to-first-address and terminal flag.
module bist_addr_cnt
  import bist_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_down ? '1 : '0;
    end else if (step) begin
      addr_d = down ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = down ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/bist_march_seq.sv
// March C- BIST sequencer for a single-port SRAM with RD_LAT-deep read compare pipe.
// Optional first-fail capture (fail_addr/fail_elem) enabled by macro BIST_FAIL_LOG_EN.
module bist_march_seq
  import bist_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 4,
  parameter int                RD_LAT     = 1,
  parameter logic [DATA_W-1:0] BG_PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BIST_FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
`endif
);

  function automatic logic [DATA_W-1:0] pattern(input logic pol);
    return pol ? ~BG_PATTERN : BG_PATTERN;
  endfunction

  bist_state_e state_q, state_d;
  march_elem_e elem_q, elem_d, elem_nxt;
  logic        phase_q, phase_d;
  logic [1:0]  drain_q, drain_d;
  logic        fail_q, fail_d;

  logic [RD_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp_q, pipe_exp_d;

  logic              cnt_load, cnt_load_down, cnt_step, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic              two_ops, op_rd, run, mismatch;

  bist_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_down(cnt_load_down),
    .step     (cnt_step),
    .down     (ELEM_DOWN[elem_q]),
    .addr     (cnt_addr),
    .last     (cnt_last)
  );

  assign run     = (state_q == RUN);
  assign two_ops = ELEM_TWO_OPS[elem_q];
  // Two-op elements read in phase 0; of the single-op elements only E5 reads.
  assign op_rd   = two_ops ? ~phase_q : (elem_q == E5);

  assign mem_re    = run & op_rd;
  assign mem_we    = run & ~op_rd;
  assign mem_addr  = run ? cnt_addr : '0;
  assign mem_wdata = mem_we ? pattern(ELEM_WR_POL[elem_q]) : '0;

  assign mismatch = pipe_vld_q[RD_LAT-1] && (mem_rdata != pipe_exp_q[RD_LAT-1]);

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign fail = fail_q;
  assign pass = done & ~fail_q;

  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    phase_d       = phase_q;
    drain_d       = drain_q;
    fail_d        = fail_q | mismatch;
    cnt_load      = 1'b0;
    cnt_load_down = 1'b0;
    cnt_step      = 1'b0;
    elem_nxt      = march_elem_e'(elem_q + 3'd1);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          elem_d   = E0;
          phase_d  = 1'b0;
          cnt_load = 1'b1;
          fail_d   = 1'b0;
        end
      end
      RUN: begin
        if (two_ops && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!cnt_last) begin
            cnt_step = 1'b1;
          end else if (elem_q == E5) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            // Next element starts at its own first address with no gap cycle.
            elem_d        = elem_nxt;
            cnt_load      = 1'b1;
            cnt_load_down = ELEM_DOWN[elem_nxt];
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(RD_LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_exp_d    = pipe_exp_q;
    pipe_vld_d[0] = mem_re;
    pipe_exp_d[0] = pattern(ELEM_RD_POL[elem_q]);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_exp_d[i] = pipe_exp_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      elem_q     <= E0;
      phase_q    <= 1'b0;
      drain_q    <= '0;
      fail_q     <= 1'b0;
      pipe_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      phase_q    <= phase_d;
      drain_q    <= drain_d;
      fail_q     <= fail_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Compare pipe data carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    pipe_exp_q <= pipe_exp_d;
  end

`ifdef BIST_FAIL_LOG_EN
  logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
  logic [RD_LAT-1:0][2:0]        pipe_elem_q, pipe_elem_d;
  logic [ADDR_W-1:0]             fail_addr_q, fail_addr_d;
  logic [2:0]                    fail_elem_q, fail_elem_d;

  always_comb begin
    pipe_addr_d    = pipe_addr_q;
    pipe_elem_d    = pipe_elem_q;
    pipe_addr_d[0] = cnt_addr;
    pipe_elem_d[0] = elem_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_addr_d[i] = pipe_addr_q[i-1];
      pipe_elem_d[i] = pipe_elem_q[i-1];
    end
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_addr_d = pipe_addr_q[RD_LAT-1];
      fail_elem_d = pipe_elem_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_ff @(posedge clk) begin
    pipe_addr_q <= pipe_addr_d;
    pipe_elem_q <= pipe_elem_d;
  end

  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
`endif

endmodule

// File: tb/tb_bist_march_seq.sv
// Bench for bist_march_seq: three configurations share one faulty-SRAM model and a march reference.
module tb_bist_march_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  int   sel;
  int   checks   = 0;
  int   failures = 0;

  // Instance A: defaults. B: ADDR_W=4, DATA_W=8, RD_LAT=3. C: defaults with BG_PATTERN=4'hA.
  logic       a_busy, a_done, a_pass, a_fail, a_we, a_re;
  logic [7:0] a_addr;
  logic [3:0] a_wdata;
  logic       b_busy, b_done, b_pass, b_fail, b_we, b_re;
  logic [3:0] b_addr;
  logic [7:0] b_wdata;
  logic       c_busy, c_done, c_pass, c_fail, c_we, c_re;
  logic [7:0] c_addr;
  logic [3:0] c_wdata;
  logic [7:0] m_rdata;
`ifdef BIST_FAIL_LOG_EN
  logic [7:0] a_fa, c_fa;
  logic [3:0] b_fa;
  logic [2:0] a_fe, b_fe, c_fe;
`endif

  bist_march_seq u_a (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
    .mem_addr(a_addr), .mem_we(a_we), .mem_re(a_re), .mem_wdata(a_wdata),
    .mem_rdata(m_rdata[3:0])
`ifdef BIST_FAIL_LOG_EN
    , .fail_addr(a_fa), .fail_elem(a_fe)
`endif
  );

  bist_march_seq #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
    .mem_addr(b_addr), .mem_we(b_we), .mem_re(b_re), .mem_wdata(b_wdata),
    .mem_rdata(m_rdata)
`ifdef BIST_FAIL_LOG_EN
    , .fail_addr(b_fa), .fail_elem(b_fe)
`endif
  );

  bist_march_seq #(.BG_PATTERN(4'hA)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2),
    .busy(c_busy), .done(c_done), .pass(c_pass), .fail(c_fail),
    .mem_addr(c_addr), .mem_we(c_we), .mem_re(c_re), .mem_wdata(c_wdata),
    .mem_rdata(m_rdata[3:0])
`ifdef BIST_FAIL_LOG_EN
    , .fail_addr(c_fa), .fail_elem(c_fe)
`endif
  );

  // Selected-instance view
  logic       m_busy, m_done, m_pass, m_fail, m_we, m_re;
  logic [7:0] m_addr, m_wdata;
  int         m_fa, m_fe;
  always_comb begin
    m_busy = a_busy; m_done = a_done; m_pass = a_pass; m_fail = a_fail;
    m_we = a_we; m_re = a_re; m_addr = a_addr; m_wdata = {4'h0, a_wdata};
    m_fa = 0; m_fe = 0;
`ifdef BIST_FAIL_LOG_EN
    m_fa = int'(a_fa); m_fe = int'(a_fe);
`endif
    if (sel == 1) begin
      m_busy = b_busy; m_done = b_done; m_pass = b_pass; m_fail = b_fail;
      m_we = b_we; m_re = b_re; m_addr = {4'h0, b_addr}; m_wdata = b_wdata;
`ifdef BIST_FAIL_LOG_EN
      m_fa = int'(b_fa); m_fe = int'(b_fe);
`endif
    end else if (sel == 2) begin
      m_busy = c_busy; m_done = c_done; m_pass = c_pass; m_fail = c_fail;
      m_we = c_we; m_re = c_re; m_addr = c_addr; m_wdata = {4'h0, c_wdata};
`ifdef BIST_FAIL_LOG_EN
      m_fa = int'(c_fa); m_fe = int'(c_fe);
`endif
    end
  end

  // Faulty SRAM model: kind 1 stuck-at, kind 2 transition 0->1 fails, kind 3 corrupt armed read.
  int         f_kind = 0, f_addr = 0, f_bit = 0, f_val = 0;
  logic       corrupt_arm = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] rd_pipe [3];

  function automatic logic [7:0] fault_write(input int a, input logic [7:0] nv, input logic [7:0] old);
    logic [7:0] v;
    v = nv;
    if (f_kind == 1 && a == f_addr) v[f_bit] = f_val[0];
    if (f_kind == 2 && a == f_addr && !old[f_bit] && v[f_bit]) v[f_bit] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= fault_write(int'(m_addr), m_wdata, mem[m_addr]);
    rd_pipe[0] <= m_re ? (mem[m_addr] ^ {7'h0, corrupt_arm}) : 8'h00;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end

  always_comb begin
    m_rdata = (sel == 1) ? rd_pipe[2] : rd_pipe[0];
  end

  // Reference: March C- op list and first-failure prediction, computed element by element.
  typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } op_t;
  op_t exp_ops [2560];

  task automatic build_model(input int n, input logic [7:0] dmask, input logic [7:0] bg,
                             output logic efail, output int efa, output int efe);
    logic [7:0] m [256];
    int dir [6] = '{0, 0, 0, 1, 1, 0};
    int rdp [6] = '{-1, 0, 1, 0, 1, 0};
    int wrp [6] = '{0, 1, 0, 1, 0, -1};
    int idx, a;
    logic [7:0] v, got;
    idx = 0; efail = 1'b0; efa = 0; efe = 0;
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        a = (dir[e] == 1) ? (n - 1 - i) : i;
        if (rdp[e] >= 0) begin
          v = (rdp[e] == 1) ? (~bg & dmask) : bg;
          got = m[a];
          if (f_kind == 3 && idx == 10 * n - 1) got = got ^ 8'h01;
          if (got != v && !efail) begin
            efail = 1'b1; efa = a; efe = e;
          end
          exp_ops[idx] = '{1'b0, 8'(a), v};
          idx++;
        end
        if (wrp[e] >= 0) begin
          v = (wrp[e] == 1) ? (~bg & dmask) : bg;
          m[a] = fault_write(a, v, m[a]);
          exp_ops[idx] = '{1'b1, 8'(a), v};
          idx++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic run_one(input string nm, input int s, input int kind, input int fa, input int fb,
                         input int fv, input int hold, input int pulse, input int use_tbl,
                         input int t_fail, input int t_fa, input int t_fe);
    int n, lat, total, ops, op_err, st_err, e3_ok, e0_ok, done_c;
    int mfa, mfe, efa, efe;
    logic mfail, efail;
    logic [7:0] dmask, bg;
    op_t e;
    n     = (s == 1) ? 16 : 256;
    lat   = (s == 1) ? 3 : 1;
    dmask = (s == 1) ? 8'hFF : 8'h0F;
    bg    = (s == 2) ? 8'h0A : 8'h00;
    total = 10 * n + lat + 1;
    @(negedge clk);
    sel = s; f_kind = kind; f_addr = fa; f_bit = fb; f_val = fv;
    build_model(n, dmask, bg, mfail, mfa, mfe);
    efail = use_tbl ? t_fail[0] : mfail;
    efa   = use_tbl ? t_fa : mfa;
    efe   = use_tbl ? t_fe : mfe;
    ops = 0; op_err = 0; st_err = 0; e3_ok = 0; e0_ok = 0; done_c = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) start = 1'b0;
    for (int c = 1; c <= total + 4; c++) begin
      @(negedge clk);
      if (m_we || m_re) begin
        if (m_we && m_re) op_err++;
        if (ops < 10 * n) begin
          e = exp_ops[ops];
          if (m_we != e.we || m_re == e.we || m_addr != e.addr ||
              (m_we && m_wdata != e.data) || c != ops + 1) op_err++;
        end
        if (ops == 5 * n) e3_ok = (m_re && m_addr == 8'(n - 1)) ? 1 : 0;
        if (ops < n && m_we && m_wdata == bg) e0_ok++;
        ops++;
      end
      if (m_busy != (c <= 10 * n + lat) || m_done != (c >= total)) st_err++;
      if (c == 1 && (m_fail || m_done || m_pass)) st_err++;
      if (m_done && done_c == 0) done_c = c;
      corrupt_arm = (kind == 3 && c == 10 * n);
      if (pulse != 0 && c == 10 * n + 1) start = 1'b1;
      if (c == total) start = 1'b0;
    end
    start = 1'b0;
    chk({nm, ".ops"}, ops, 10 * n);
    chk({nm, ".op_stream_errs"}, op_err, 0);
    chk({nm, ".busy_done_errs"}, st_err, 0);
    chk({nm, ".done_cycle"}, done_c, total);
    chk({nm, ".e3_first_read_top"}, e3_ok, 1);
    chk({nm, ".e0_writes_bg"}, e0_ok, n);
    chk({nm, ".fail"}, int'(m_fail), int'(efail));
    chk({nm, ".pass"}, int'(m_pass), int'(!efail));
`ifdef BIST_FAIL_LOG_EN
    chk({nm, ".fail_addr"}, m_fa, efail ? efa : 0);
    chk({nm, ".fail_elem"}, m_fe, efail ? efe : 0);
`endif
  endtask

  typedef struct {
    int s, kind, fa, fb, fv, hold, pulse, efail, efa, efe;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 0,    0, 0, 0, 0, 0, 0,  0};
    tbl[1] = '{0, 1, 8'h37, 2, 0, 0, 0, 1, 8'h37, 2};
    tbl[2] = '{2, 2, 0,    0, 0, 0, 0, 1, 0,  2};
    tbl[3] = '{1, 0, 0,    0, 0, 0, 0, 0, 0,  0};
    tbl[4] = '{1, 3, 0,    0, 0, 0, 0, 1, 15, 5};
    tbl[5] = '{0, 0, 0,    0, 0, 1, 0, 0, 0,  0};
    tbl[6] = '{0, 1, 8'h37, 2, 0, 0, 1, 1, 8'h37, 2};
    tbl[7] = '{0, 0, 0,    0, 0, 0, 1, 0, 0,  0};

    rst_n = 1'b0; start = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.a", int'({a_busy, a_done, a_pass, a_fail, a_we, a_re, |a_addr, |a_wdata}), 0);
    chk("reset.b", int'({b_busy, b_done, b_pass, b_fail, b_we, b_re, |b_addr, |b_wdata}), 0);
    chk("reset.c", int'({c_busy, c_done, c_pass, c_fail, c_we, c_re, |c_addr, |c_wdata}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i].s, tbl[i].kind, tbl[i].fa, tbl[i].fb, tbl[i].fv,
              tbl[i].hold, tbl[i].pulse, 1, tbl[i].efail, tbl[i].efa, tbl[i].efe);
    end

    // Mid-run reset while a stuck-at fault has already been flagged
    @(negedge clk);
    sel = 0; f_kind = 1; f_addr = 8'h37; f_bit = 2; f_val = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (999) @(negedge clk);
    chk("midrun.fail_before_reset", int'(a_fail), 1);
    chk("midrun.busy_before_reset", int'(a_busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun.after_reset", int'({a_we, a_re, a_busy, a_done, a_fail, a_pass, |a_addr}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 5; r++) begin
      int s, k;
      s = int'($urandom_range(0, 2));
      k = int'($urandom_range(0, 3));
      run_one($sformatf("rand%0d", r), s, k,
              int'($urandom_range(0, (s == 1) ? 15 : 255)),
              int'($urandom_range(0, (s == 1) ? 7 : 3)),
              int'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
